aes128_key_expand: RTL and testbench
====================================

// Module: aes128_key_expand
// PURPOSE
// Sequential AES-128 key schedule (FIPS-197). It is the stage directly upstream of the encryption datapath.
// Expands one 128-bit cipher key into round keys 1..10, computing one round key per clock.
// Holds all ten round keys stable on dedicated outputs, which feed the round1_key..round10_key inputs of
// the encryption top. key_valid tells the consumer when the full set can be used.
// PARAMETERS
// CLEAR_ON_START  1  1: round-key outputs are zeroed when a start is accepted; 0: old keys are held until overwritten
// PORTS
// clk           in   1    single clock; all state updates on posedge
// reset         in   1    asynchronous, active-low reset (0 = reset asserted)
// start         in   1    request expansion of key; sampled on posedge
// key           in   128  cipher key; w0 = key[127:96] .. w3 = key[31:0]; sampled only on an accepted start
// busy          out  1    expansion in progress
// done          out  1    one-cycle pulse: full key set has just been written
// key_valid     out  1    round1..round10 keys are complete for the last accepted key
// round1_key .. round10_key  out  128 each  registered round keys; same word ordering as key
// BEHAVIOUR
// - Reset (reset=0, async): FSM=IDLE, rcnt=0, busy=0, done=0, key_valid=0, all roundN_key=0, internal key reg=0.
// - FSM states: IDLE, EXPAND, DONE.
//   IDLE   -> EXPAND when start=1; the edge loads the working reg from key, sets rcnt=1 and rcon=8'h01.
//   EXPAND -> writes roundN_key (N=rcnt) each edge; stays in EXPAND while rcnt<10; goes to DONE on the edge that writes round10.
//   DONE   -> IDLE next edge; a start seen in DONE is accepted exactly as in IDLE (goes to EXPAND).
// - Timing (E0 = edge that accepts start): round1 is written at E1, roundN at EN, round10 at E10.
//   busy=1 from after E0 until after E10; done=1 for exactly the cycle after E10; key_valid rises at E10.
// - Accepted start: key_valid is cleared at E0. If CLEAR_ON_START=1, all roundN_key are also zeroed at E0.
// - start while busy=1 is ignored: no restart, key is not resampled.
// - Round step: prev = working reg {w0,w1,w2,w3}.
//   t  = SubWord(RotWord(w3)) ^ {rcon,24'h0}; RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
//   n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2. The working reg and roundN_key both take {n0,n1,n2,n3}.
// - rcon sequence: 01,02,04,08,10,20,40,80,1b,36. Next rcon = xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
//   Wrap 80->1b is required.
// - SubWord uses 4 parallel copies of a block-internal 256-entry AES forward S-box, purely combinational
//   (1 round per cycle). No dependency on other modules.
// - Outputs are registered. Round keys change only on write edges or reset, never combinationally from key.
// - Reset mid-expansion: immediate return to reset values. After release, the block needs a new start;
//   no partial key set survives (key_valid=0).
// - key changing while busy has no effect.
// TESTING
// 1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> round1=a0fafe1788542cb123a339392a6c7605,
//   round10=d014f9a8c9ee2589e13f0cc8b6630ca6; done 1 cycle after E10; key_valid=1.
// 2 Key 0 -> round1=62636363626363636263636362636363, round10=b4ef5bcb3e92e21123e951cf6f8f188e.
// 3 Latency/handshake: check busy high from after E0 to after E10, done high exactly 1 cycle, then IDLE.
//   Start held high through the run -> no restart; next expansion begins only from DONE/IDLE.
// 4 Back-to-back: key A, then start in DONE cycle with key B -> B keys correct; key_valid low during B expansion;
//   with CLEAR_ON_START=1 outputs read 0 at E1-1.
// 5 reset=0 at E5 of an expansion -> all outputs 0 asynchronously. After release and a new start with the
//   FIPS key -> correct full set.
// 6 CLEAR_ON_START=0: after key A, start key B -> round6..10 still show A values until E6..E10 overwrite them.

Source files
------------

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: expands one cipher key into round keys 1..10,
// one round key per clock, and holds the full set on registered outputs.
module aes128_key_expand #(
    parameter logic CLEAR_ON_START = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    output logic [127:0] round1_key,
    output logic [127:0] round2_key,
    output logic [127:0] round3_key,
    output logic [127:0] round4_key,
    output logic [127:0] round5_key,
    output logic [127:0] round6_key,
    output logic [127:0] round7_key,
    output logic [127:0] round8_key,
    output logic [127:0] round9_key,
    output logic [127:0] round10_key
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // AES forward S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         state, state_nxt;
    logic           accept;
    logic [3:0]     rcnt;
    logic [7:0]     rcon;
    logic [127:0]   wreg;
    logic [127:0]   nxt_key;
    logic [127:0]   rk [1:10];

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] round_step(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
        n0 = w[127:96] ^ t;
        n1 = w[95:64]  ^ n0;
        n2 = w[63:32]  ^ n1;
        n3 = w[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign nxt_key = round_step(wreg, rcon);

    // A start is honoured in IDLE and DONE alike; while expanding it is ignored
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                if (rcnt == 4'd10) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            rcnt      <= 4'd0;
            rcon      <= 8'h00;
            wreg      <= '0;
            for (int i = 1; i <= 10; i++) rk[i] <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == EXPAND);
            done  <= (state_nxt == DONE);
            if (accept) begin
                wreg      <= key;
                rcnt      <= 4'd1;
                rcon      <= 8'h01;
                key_valid <= 1'b0;
                if (CLEAR_ON_START) begin
                    for (int i = 1; i <= 10; i++) rk[i] <= '0;
                end
            end else if (state == EXPAND) begin
                wreg <= nxt_key;
                for (int i = 1; i <= 10; i++) begin
                    if (rcnt == i[3:0]) rk[i] <= nxt_key;
                end
                rcnt <= rcnt + 4'd1;
                rcon <= xtime(rcon);
                if (rcnt == 4'd10) key_valid <= 1'b1;
            end
        end
    end

    assign round1_key  = rk[1];
    assign round2_key  = rk[2];
    assign round3_key  = rk[3];
    assign round4_key  = rk[4];
    assign round5_key  = rk[5];
    assign round6_key  = rk[6];
    assign round7_key  = rk[7];
    assign round8_key  = rk[8];
    assign round9_key  = rk[9];
    assign round10_key = rk[10];

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand: FIPS-197 and all-zero keys, handshake timing,
// back-to-back starts, mid-run reset, and hold-until-overwrite behaviour.
module tb_aes128_key_expand;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic [127:0] key = '0;

    logic         busy0, done0, kv0, busy1, done1, kv1;
    logic [127:0] rk0 [1:10];
    logic [127:0] rk1 [1:10];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [127:0] fips_rk [1:10];

    always #5 clk = ~clk;

    aes128_key_expand #(.CLEAR_ON_START(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .key(key),
        .busy(busy0), .done(done0), .key_valid(kv0),
        .round1_key(rk0[1]), .round2_key(rk0[2]), .round3_key(rk0[3]), .round4_key(rk0[4]),
        .round5_key(rk0[5]), .round6_key(rk0[6]), .round7_key(rk0[7]), .round8_key(rk0[8]),
        .round9_key(rk0[9]), .round10_key(rk0[10])
    );

    aes128_key_expand #(.CLEAR_ON_START(1'b0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .key(key),
        .busy(busy1), .done(done1), .key_valid(kv1),
        .round1_key(rk1[1]), .round2_key(rk1[2]), .round3_key(rk1[3]), .round4_key(rk1[4]),
        .round5_key(rk1[5]), .round6_key(rk1[6]), .round7_key(rk1[7]), .round8_key(rk1[8]),
        .round9_key(rk1[9]), .round10_key(rk1[10])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_fips_set(input string tag);
        for (int i = 1; i <= 10; i++) chk($sformatf("%s_r%0d", tag, i), rk0[i], fips_rk[i]);
    endtask

    // Start on dut0 with a one-cycle pulse; returns just after E0
    task automatic start_pulse0(input logic [127:0] k);
        key    = k;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    initial begin
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        tick(3);
        reset = 1'b1;
        tick();
        chk("rst_busy", {127'b0, busy0}, 128'd0);
        chk("rst_done", {127'b0, done0}, 128'd0);
        chk("rst_kv", {127'b0, kv0}, 128'd0);
        chk("rst_r1", rk0[1], 128'd0);
        chk("rst_r10", rk0[10], 128'd0);

        // FIPS-197 key, full timing
        start_pulse0(FIPS_KEY);
        chk("t1_busy_e0", {127'b0, busy0}, 128'd1);
        chk("t1_kv_e0", {127'b0, kv0}, 128'd0);
        tick();
        chk("t1_r1_e1", rk0[1], fips_rk[1]);
        tick(8);
        chk("t1_busy_e9", {127'b0, busy0}, 128'd1);
        chk("t1_done_e9", {127'b0, done0}, 128'd0);
        chk("t1_kv_e9", {127'b0, kv0}, 128'd0);
        tick();
        chk("t1_busy_e10", {127'b0, busy0}, 128'd0);
        chk("t1_done_e10", {127'b0, done0}, 128'd1);
        chk("t1_kv_e10", {127'b0, kv0}, 128'd1);
        chk_fips_set("t1");
        tick();
        chk("t1_done_e11", {127'b0, done0}, 128'd0);
        chk("t1_busy_e11", {127'b0, busy0}, 128'd0);
        chk("t1_kv_e11", {127'b0, kv0}, 128'd1);

        // Start held high, key changed mid-run: no restart, no resample
        key    = FIPS_KEY;
        start0 = 1'b1;
        tick();
        key = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        tick(9);
        chk("t3_done_e9", {127'b0, done0}, 128'd0);
        tick();
        chk("t3_done_e10", {127'b0, done0}, 128'd1);
        chk("t3_r1", rk0[1], fips_rk[1]);
        chk("t3_r10", rk0[10], fips_rk[10]);
        tick();
        chk("t3_restart_busy", {127'b0, busy0}, 128'd1);
        chk("t3_restart_kv", {127'b0, kv0}, 128'd0);
        chk("t3_restart_done", {127'b0, done0}, 128'd0);
        start0 = 1'b0;
        tick(10);
        chk("t3_done2", {127'b0, done0}, 128'd1);
        chk("t3_kv2", {127'b0, kv0}, 128'd1);
        tick();

        // Back-to-back: key A then start in DONE with zero key
        start_pulse0(FIPS_KEY);
        tick(10);
        chk("t4_doneA", {127'b0, done0}, 128'd1);
        start_pulse0(128'd0);
        chk("t4_busyB", {127'b0, busy0}, 128'd1);
        chk("t4_kvB_e0", {127'b0, kv0}, 128'd0);
        chk("t4_clr_r1", rk0[1], 128'd0);
        chk("t4_clr_r10", rk0[10], 128'd0);
        tick();
        chk("t4_r1_e1", rk0[1], Z_R1);
        chk("t4_kv_e1", {127'b0, kv0}, 128'd0);
        tick(9);
        chk("t4_r10", rk0[10], Z_R10);
        chk("t4_r1", rk0[1], Z_R1);
        chk("t4_kv_e10", {127'b0, kv0}, 128'd1);
        tick();

        // Asynchronous reset at E5
        start_pulse0(FIPS_KEY);
        tick(5);
        chk("t5_r5_pre", rk0[5], fips_rk[5]);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy", {127'b0, busy0}, 128'd0);
        chk("t5_kv", {127'b0, kv0}, 128'd0);
        chk("t5_r1", rk0[1], 128'd0);
        chk("t5_r5", rk0[5], 128'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("t5_idle_busy", {127'b0, busy0}, 128'd0);
        chk("t5_idle_kv", {127'b0, kv0}, 128'd0);
        start_pulse0(FIPS_KEY);
        tick(10);
        chk("t5_done", {127'b0, done0}, 128'd1);
        chk_fips_set("t5");

        // CLEAR_ON_START=0: old keys held until overwritten
        key    = FIPS_KEY;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(10);
        chk("t6_doneA", {127'b0, done1}, 128'd1);
        chk("t6_r10A", rk1[10], fips_rk[10]);
        key    = 128'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t6_kv_e0", {127'b0, kv1}, 128'd0);
        chk("t6_r1_e0", rk1[1], fips_rk[1]);
        tick();
        chk("t6_r1_e1", rk1[1], Z_R1);
        chk("t6_r6_e1", rk1[6], fips_rk[6]);
        tick(4);
        chk("t6_r6_e5", rk1[6], fips_rk[6]);
        tick(4);
        chk("t6_r10_e9", rk1[10], fips_rk[10]);
        chk("t6_kv_e9", {127'b0, kv1}, 128'd0);
        tick();
        chk("t6_r10_e10", rk1[10], Z_R10);
        chk("t6_kv_e10", {127'b0, kv1}, 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
